xfer_receiver: RTL
==================

XFER_RECEIVER -- requirements
Module: xfer_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 32, message data width.
REQ-002 SHALL have parameter ADDR_W, default 6, data-memory word address width.
REQ-003 SHALL have parameter DEPTH, default 4, message FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port xfer_valid, input, 1, transfer controller offers a message.
REQ-007 SHALL have port xfer_ready, output, 1, receiver can accept a message this cycle.
REQ-008 SHALL have port xfer_src, input, 2, source core index.
REQ-009 SHALL have port xfer_addr, input, ADDR_W, shared address written by the source core.
REQ-010 SHALL have port xfer_data, input, DATA_W, data written by the source core.
REQ-011 SHALL have port rd_addr, input, ADDR_W, target core load address.
REQ-012 SHALL have port rd_pop, input, 1, target core consumes the head message.
REQ-013 SHALL have port rd_hit, output, 1, head message valid and rd_addr matches its address.
REQ-014 SHALL have port rd_data, output, DATA_W, head data when rd_hit, else zero.
REQ-015 SHALL have port msg_pending, output, 1, head message presentable to the core.
REQ-016 SHALL have port done_valid, output, 1, one-cycle completion pulse to the controller.
REQ-017 SHALL have port done_src, output, 2, source index of the completed message.
REQ-018 SHALL have port count, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-019 SHALL have port err, output, 2, sticky flags: [0] overflow, [1] underflow.

Function
REQ-020 SHALL assert xfer_ready exactly when count < DEPTH; a pop in the same cycle does not raise xfer_ready.
REQ-021 SHALL enqueue {xfer_src, xfer_addr, xfer_data} on a rising edge where xfer_valid and xfer_ready are both high; count updates the same edge.
REQ-022 SHALL set err[0] when xfer_valid is high while xfer_ready is low; the message is dropped.
REQ-023 SHALL implement FSM states IDLE (empty), HOLD (head presented), ACK (completion pulse).
REQ-024 SHALL transition IDLE->HOLD on the edge after the first enqueue; msg_pending is high only in HOLD.
REQ-025 SHALL drive rd_hit and rd_data combinationally from the head entry and rd_addr, with zero latency.
REQ-026 SHALL, in HOLD with rd_pop high, dequeue the head, latch its source into done_src, and go to ACK.
REQ-027 SHALL drive done_valid high for exactly the one cycle spent in ACK.
REQ-028 SHALL hold done_src stable until the next ACK.
REQ-029 SHALL transition ACK->HOLD if count > 0, else ACK->IDLE; the sustained consumption rate is therefore one message per 2 cycles.
REQ-030 SHALL set err[1] when rd_pop is high outside HOLD; state and FIFO are unchanged.
REQ-031 SHALL, on a simultaneous accepted enqueue and pop, keep count unchanged; read and write pointers wrap modulo DEPTH.
REQ-032 SHALL clear err only on reset.

Reset
REQ-033 SHALL, while reset is low, force: state IDLE, pointers 0, count 0, xfer_ready 1, msg_pending 0, rd_hit 0, rd_data 0, done_valid 0, done_src 0, err 0.
REQ-034 SHALL discard all buffered messages on reset mid-operation, including in ACK, with no done_valid pulse emitted.
REQ-035 SHALL leave the FIFO storage array unreset; only control state is reset.

Structure
REQ-036 SHALL take the FSM state encoding and the core-index width (2) from a shared package, xfer_pkg, which the transfer controller also uses.
REQ-037 SHALL contain one sub-module, xfer_fifo (parameterised sync FIFO, outputs full/empty/count); the FSM and hit logic stay in xfer_receiver.

Verification
REQ-038 SHALL pass: push src=2, addr=0x05, data=0xDEADBEEF; rd_addr=0x05 -> rd_hit=1, rd_data=0xDEADBEEF; rd_pop -> next cycle done_valid=1 for 1 cycle, done_src=2.
REQ-039 SHALL pass: head addr=0x05 with rd_addr=0x06 -> rd_hit=0, rd_data=0.
REQ-040 SHALL pass: 5 pushes with DEPTH=4 and no pops -> count=4, xfer_ready=0, err[0]=1, 5th message absent.
REQ-041 SHALL pass: 4 queued messages with rd_pop held high -> done_valid pulses on cycles 2,4,6,8, done_src in push order, then IDLE with count=0.
REQ-042 SHALL pass: rd_pop in IDLE -> err[1]=1, count=0; reset low mid-HOLD with 3 queued -> count=0, msg_pending=0, no done_valid.
REQ-043 SHALL pass: count=4, simultaneous push and pop in HOLD -> push rejected (err[0]=1), count=3 after pop.

Source files
------------

// File: rtl/xfer_pkg.sv
// Shared definitions for the core-to-core transfer path: core index width and
// the receiver FSM encoding, also used by the transfer controller.
package xfer_pkg;
  localparam int SRC_W = 2;

  typedef logic [SRC_W-1:0] src_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
endpackage

// File: rtl/xfer_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full, pop when empty.
// Only pointers and count are reset; the storage array is left uninitialised.
module xfer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/xfer_receiver.sv
// Receiving side of a core-to-core transfer: buffers messages, presents the head
// to the target core, and returns a one-cycle completion pulse per consumed message.
module xfer_receiver
  import xfer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   xfer_valid,
  output logic                   xfer_ready,
  input  logic [SRC_W-1:0]       xfer_src,
  input  logic [ADDR_W-1:0]      xfer_addr,
  input  logic [DATA_W-1:0]      xfer_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_pop,
  output logic                   rd_hit,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   msg_pending,
  output logic                   done_valid,
  output logic [SRC_W-1:0]       done_src,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             err
);
  typedef struct packed {
    src_t              src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [1:0] r_state;
  src_t       r_done_src;
  logic [1:0] r_err;
  entry_t     w_head;
  entry_t     w_wentry;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;

  assign w_wentry = '{src: xfer_src, addr: xfer_addr, data: xfer_data};
  assign w_pop    = (r_state == ST_HOLD) && rd_pop;

  xfer_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (xfer_valid),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_done_src <= '0;
      r_err      <= '0;
    end else begin
      if (xfer_valid && w_full)         r_err[0] <= 1'b1;
      if (rd_pop && r_state != ST_HOLD) r_err[1] <= 1'b1;
      case (r_state)
        ST_IDLE: if (!w_empty) r_state <= ST_HOLD;
        ST_HOLD: begin
          if (rd_pop) begin
            r_state    <= ST_ACK;
            r_done_src <= w_head.src;
          end
        end
        // Occupancy is sampled after the pop, so a drained FIFO returns to IDLE.
        ST_ACK:  r_state <= w_empty ? ST_IDLE : ST_HOLD;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign xfer_ready  = !w_full;
  assign msg_pending = (r_state == ST_HOLD);
  assign rd_hit      = msg_pending && (w_head.addr == rd_addr);
  assign rd_data     = rd_hit ? w_head.data : '0;
  assign done_valid  = (r_state == ST_ACK);
  assign done_src    = r_done_src;
  assign err         = r_err;
endmodule
